// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Two-way arbiter for the UART transmit byte stream. Grants
//               the CPU (req0) or debug (req1) source for a whole message
//               and releases on a last byte, a byte-count limit or an idle
//               timeout. Ties are broken round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int HOLD_MAX     = 64,
   parameter int IDLE_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req0_data,
   input  logic       req0_valid,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic [7:0] req1_data,
   input  logic       req1_valid,
   input  logic       req1_last,
   output logic       req1_ready,
   output logic [7:0] uart_data,
   output logic       uart_valid,
   input  logic       uart_ready,
   output logic [1:0] grant,
   output logic       busy
);

   localparam logic [7:0]  c_hold_max     = 8'(HOLD_MAX);
   localparam logic [15:0] c_idle_timeout = 16'(IDLE_TIMEOUT);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OWN  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;      // 0 = req0 (CPU), 1 = req1 (debug)
   logic        rr_last_q, rr_last_d;  // owner of the most recent grant
   logic [7:0]  byte_cnt_q, byte_cnt_d;
   logic [15:0] idle_cnt_q, idle_cnt_d;
   logic [1:0]  grant_q, grant_d;

   logic        w_in_own;
   logic        w_own_valid;
   logic        w_own_last;
   logic [7:0]  w_own_data;
   logic        w_xfer;
   logic [7:0]  w_byte_cnt_inc;
   logic [15:0] w_idle_cnt_inc;
   logic        w_release;
   logic        w_pick;

   // Select the current owner's byte stream and decide whether the grant ends
   always_comb begin
      w_in_own       = (state_q == ST_OWN);
      w_own_valid    = owner_q ? req1_valid : req0_valid;
      w_own_last     = owner_q ? req1_last  : req0_last;
      w_own_data     = owner_q ? req1_data  : req0_data;
      w_xfer         = w_in_own & w_own_valid & uart_ready;
      w_byte_cnt_inc = byte_cnt_q + 8'd1;
      w_idle_cnt_inc = idle_cnt_q + 16'd1;
      // A stalled uart with valid held high is not idleness, so the timeout
      // only considers cycles where the owner has nothing to offer.
      w_release      = w_in_own &
                       ((w_xfer & w_own_last) |
                        (w_xfer & (w_byte_cnt_inc == c_hold_max)) |
                        (~w_own_valid & (w_idle_cnt_inc == c_idle_timeout)));
      // On a tie the requester that did not own the bus last time wins
      w_pick         = (req0_valid & req1_valid) ? ~rr_last_q : req1_valid;
   end

   // Next-state logic for the grant FSM and its counters
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_last_d  = rr_last_q;
      byte_cnt_d = byte_cnt_q;
      idle_cnt_d = idle_cnt_q;
      grant_d    = grant_q;
      case (state_q)
         ST_IDLE: begin
            byte_cnt_d = 8'd0;
            idle_cnt_d = 16'd0;
            if (req0_valid | req1_valid) begin
               state_d = ST_OWN;
               owner_d = w_pick;
               grant_d = w_pick ? 2'b10 : 2'b01;
            end
         end
         ST_OWN: begin
            if (w_release) begin
               // Mandatory idle cycle afterwards gives the other side a turn
               state_d    = ST_IDLE;
               rr_last_d  = owner_q;
               byte_cnt_d = 8'd0;
               idle_cnt_d = 16'd0;
               grant_d    = 2'b00;
            end else begin
               byte_cnt_d = w_xfer ? w_byte_cnt_inc : byte_cnt_q;
               idle_cnt_d = w_own_valid ? 16'd0 : w_idle_cnt_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   // State registers; reset forces IDLE immediately, abandoning any message
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= 1'b0;
         rr_last_q  <= 1'b1;
         byte_cnt_q <= 8'd0;
         idle_cnt_q <= 16'd0;
         grant_q    <= 2'b00;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_last_q  <= rr_last_d;
         byte_cnt_q <= byte_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         grant_q    <= grant_d;
      end
   end

   // Owner's stream passes straight through; everything is 0 outside OWN
   always_comb begin
      uart_valid = w_in_own & w_own_valid;
      uart_data  = w_in_own ? w_own_data : 8'h00;
      req0_ready = w_in_own & ~owner_q & uart_ready;
      req1_ready = w_in_own &  owner_q & uart_ready;
      grant      = grant_q;
      busy       = w_in_own;
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter with
//               HOLD_MAX=4 and IDLE_TIMEOUT=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req0_data;
   logic       req0_valid;
   logic       req0_last;
   logic       req0_ready;
   logic [7:0] req1_data;
   logic       req1_valid;
   logic       req1_last;
   logic       req1_ready;
   logic [7:0] uart_data;
   logic       uart_valid;
   logic       uart_ready;
   logic [1:0] grant;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Per-requester message sources: byte n is base+n, last every len bytes
   // (len 0 = never), and the requester is valid until total bytes are sent.
   logic [7:0] r0_base, r1_base;
   int         r0_len, r1_len, r0_total, r1_total;
   int         idx0, idx1;

   uart_tx_arbiter #(
      .HOLD_MAX     (4),
      .IDLE_TIMEOUT (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_data  (req0_data),
      .req0_valid (req0_valid),
      .req0_last  (req0_last),
      .req0_ready (req0_ready),
      .req1_data  (req1_data),
      .req1_valid (req1_valid),
      .req1_last  (req1_last),
      .req1_ready (req1_ready),
      .uart_data  (uart_data),
      .uart_valid (uart_valid),
      .uart_ready (uart_ready),
      .grant      (grant),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive sources, check one cycle's outputs, advance a clock, count transfers
   task automatic run_cycle(input logic [1:0] eg, input logic ev, input logic [7:0] ed);
      logic x0, x1;
      req0_valid = (idx0 < r0_total);
      req0_data  = r0_base + 8'(idx0);
      req0_last  = (r0_len == 0) ? 1'b0 : ((idx0 % r0_len) == (r0_len - 1));
      req1_valid = (idx1 < r1_total);
      req1_data  = r1_base + 8'(idx1);
      req1_last  = (r1_len == 0) ? 1'b0 : ((idx1 % r1_len) == (r1_len - 1));
      #1;
      chk("grant", 16'(grant), 16'(eg));
      chk("busy", 16'(busy), 16'(eg != 2'b00));
      chk("uart_valid", 16'(uart_valid), 16'(ev));
      if (ev) chk("uart_data", 16'(uart_data), 16'(ed));
      chk("req0_ready", 16'(req0_ready), 16'((eg == 2'b01) && uart_ready));
      chk("req1_ready", 16'(req1_ready), 16'((eg == 2'b10) && uart_ready));
      x0 = req0_valid & req0_ready;
      x1 = req1_valid & req1_ready;
      @(posedge clk);
      #1;
      if (x0) idx0++;
      if (x1) idx1++;
   endtask

   initial begin
      rst_n      = 1'b0;
      uart_ready = 1'b1;
      req0_data  = 8'h00; req0_valid = 1'b0; req0_last = 1'b0;
      req1_data  = 8'h00; req1_valid = 1'b0; req1_last = 1'b0;

      // Reset with both requesting, then a 3-byte CPU message and a 1-byte debug one
      r0_base = 8'h41; r0_len = 3; r0_total = 3; idx0 = 0;
      r1_base = 8'hA0; r1_len = 1; r1_total = 1; idx1 = 0;
      @(posedge clk); #1;
      run_cycle(2'b00, 1'b0, 8'h00);
      run_cycle(2'b00, 1'b0, 8'h00);
      rst_n = 1'b1;
      run_cycle(2'b00, 1'b0, 8'h00);
      run_cycle(2'b01, 1'b1, 8'h41);
      run_cycle(2'b01, 1'b1, 8'h42);
      run_cycle(2'b01, 1'b1, 8'h43);
      run_cycle(2'b00, 1'b0, 8'h00);
      run_cycle(2'b10, 1'b1, 8'hA0);
      run_cycle(2'b00, 1'b0, 8'h00);
      run_cycle(2'b00, 1'b0, 8'h00);

      // Contention: both stream 2-byte messages, grants alternate with idle gaps
      r0_base = 8'h50; r0_len = 2; r0_total = 4; idx0 = 0;
      r1_base = 8'h60; r1_len = 2; r1_total = 4; idx1 = 0;
      run_cycle(2'b00, 1'b0, 8'h00);
      run_cycle(2'b01, 1'b1, 8'h50);
      run_cycle(2'b01, 1'b1, 8'h51);
      run_cycle(2'b00, 1'b0, 8'h00);
      run_cycle(2'b10, 1'b1, 8'h60);
      run_cycle(2'b10, 1'b1, 8'h61);
      run_cycle(2'b00, 1'b0, 8'h00);
      run_cycle(2'b01, 1'b1, 8'h52);
      run_cycle(2'b01, 1'b1, 8'h53);
      run_cycle(2'b00, 1'b0, 8'h00);
      run_cycle(2'b10, 1'b1, 8'h62);
      run_cycle(2'b10, 1'b1, 8'h63);
      run_cycle(2'b00, 1'b0, 8'h00);

      // Hold limit: debug streams 10 bytes with no last while CPU waits
      r0_base = 8'h30; r0_len = 1; r0_total = 0; idx0 = 0;
      r1_base = 8'h70; r1_len = 0; r1_total = 10; idx1 = 0;
      run_cycle(2'b00, 1'b0, 8'h00);
      r0_total = 1;
      run_cycle(2'b10, 1'b1, 8'h70);
      run_cycle(2'b10, 1'b1, 8'h71);
      run_cycle(2'b10, 1'b1, 8'h72);
      run_cycle(2'b10, 1'b1, 8'h73);
      run_cycle(2'b00, 1'b0, 8'h00);
      run_cycle(2'b01, 1'b1, 8'h30);
      run_cycle(2'b00, 1'b0, 8'h00);
      run_cycle(2'b10, 1'b1, 8'h74);
      run_cycle(2'b10, 1'b1, 8'h75);
      run_cycle(2'b10, 1'b1, 8'h76);
      run_cycle(2'b10, 1'b1, 8'h77);
      run_cycle(2'b00, 1'b0, 8'h00);
      run_cycle(2'b10, 1'b1, 8'h78);
      run_cycle(2'b10, 1'b1, 8'h79);
      // Stream exhausted without last: the grant lingers until the timeout
      for (int i = 0; i < 8; i++) run_cycle(2'b10, 1'b0, 8'h00);
      run_cycle(2'b00, 1'b0, 8'h00);

      // Timeout: one CPU byte then valid drops; revoked 8 cycles later
      r0_base = 8'h90; r0_len = 0; r0_total = 1; idx0 = 0;
      r1_total = 0; idx1 = 0;
      run_cycle(2'b00, 1'b0, 8'h00);
      run_cycle(2'b01, 1'b1, 8'h90);
      for (int i = 0; i < 8; i++) run_cycle(2'b01, 1'b0, 8'h00);
      run_cycle(2'b00, 1'b0, 8'h00);

      // A 20-cycle uart stall with valid high holds data and never times out
      r1_base = 8'hA0; r1_len = 2; r1_total = 2; idx1 = 0;
      r0_total = 0;
      run_cycle(2'b00, 1'b0, 8'h00);
      uart_ready = 1'b0;
      for (int i = 0; i < 20; i++) run_cycle(2'b10, 1'b1, 8'hA0);
      uart_ready = 1'b1;
      run_cycle(2'b10, 1'b1, 8'hA0);
      run_cycle(2'b10, 1'b1, 8'hA1);
      run_cycle(2'b00, 1'b0, 8'h00);

      // Reset mid-message clears all outputs without waiting for a clock
      r0_base = 8'hC0; r0_len = 3; r0_total = 3; idx0 = 0;
      r1_total = 0;
      run_cycle(2'b00, 1'b0, 8'h00);
      run_cycle(2'b01, 1'b1, 8'hC0);
      req0_data = 8'hC1; req0_valid = 1'b1; req0_last = 1'b0;
      #1;
      chk("mid_uart_valid", 16'(uart_valid), 16'd1);
      chk("mid_uart_data", 16'(uart_data), 16'h00C1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_grant", 16'(grant), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_uart_valid", 16'(uart_valid), 16'd0);
      chk("rst_uart_data", 16'(uart_data), 16'd0);
      chk("rst_req0_ready", 16'(req0_ready), 16'd0);
      chk("rst_req1_ready", 16'(req1_ready), 16'd0);
      r0_total = 0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      run_cycle(2'b00, 1'b0, 8'h00);
      run_cycle(2'b00, 1'b0, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
